sdes_decrypt_engine: RTL and testbench

- Multi-cycle S-DES decryptor. It is the receive-side counterpart of the team's combinational encrypt path.
- Accepts one 8-bit ciphertext and one 10-bit master key through a valid/ready handshake.
- Generates subkeys K1/K2 internally, then applies IP, fK(K2), SW, fK(K1), IP^-1 over successive cycles.
- Returns the 8-bit plaintext through a valid/ready handshake. It sits between the link receiver and the consumer of plaintext bytes.

---
 rtl/sdes_pkg.sv | 89 ++++++++
 rtl/sdes_decrypt_engine_if.sv | 22 ++
 rtl/sdes_keygen.sv | 16 +
 rtl/sdes_decrypt_engine.sv | 113 +++++++++++
 tb/tb_sdes_decrypt_engine.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/sdes_pkg.sv
// Shared S-DES definitions: permutation tables, S-boxes, FSM states and the
// round/key helper functions used by both the encrypt and decrypt paths.
package sdes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEYGEN,
        RND_A,
        RND_B,
        OUT
    } state_e;

    // Each table entry is a 1-based source position counted from the leftmost bit,
    // packed leftmost-entry-first into the low 4*width bits.
    localparam logic [39:0] P10_IDX    = {4'd3, 4'd5, 4'd2, 4'd7, 4'd4, 4'd10, 4'd1, 4'd9, 4'd8, 4'd6};
    localparam logic [39:0] P8_IDX     = {8'd0, 4'd6, 4'd3, 4'd7, 4'd4, 4'd8, 4'd5, 4'd10, 4'd9};
    localparam logic [39:0] P4_IDX     = {24'd0, 4'd2, 4'd4, 4'd3, 4'd1};
    localparam logic [39:0] IP_IDX     = {8'd0, 4'd2, 4'd6, 4'd3, 4'd1, 4'd4, 4'd8, 4'd5, 4'd7};
    localparam logic [39:0] IP_INV_IDX = {8'd0, 4'd4, 4'd1, 4'd3, 4'd5, 4'd7, 4'd2, 4'd8, 4'd6};
    localparam logic [39:0] EP_IDX     = {8'd0, 4'd4, 4'd1, 4'd2, 4'd3, 4'd2, 4'd3, 4'd4, 4'd1};

    // Indexed by {row, col}, row-major.
    localparam logic [1:0] S0_TBL [16] = '{2'd1, 2'd0, 2'd3, 2'd2,
                                           2'd3, 2'd2, 2'd1, 2'd0,
                                           2'd0, 2'd2, 2'd1, 2'd3,
                                           2'd3, 2'd1, 2'd3, 2'd2};
    localparam logic [1:0] S1_TBL [16] = '{2'd0, 2'd1, 2'd2, 2'd3,
                                           2'd2, 2'd0, 2'd1, 2'd3,
                                           2'd3, 2'd0, 2'd1, 2'd0,
                                           2'd2, 2'd1, 2'd0, 2'd3};

    function automatic logic [9:0] permute(input logic [9:0] src, input int srcW,
                                           input logic [39:0] idx, input int outW);
        logic [9:0] res;
        int pos;
        res = '0;
        for (int k = 0; k < outW; k++) begin
            pos = int'(idx[6'(4 * (outW - 1 - k)) +: 4]);
            res[4'(outW - 1 - k)] = src[4'(srcW - pos)];
        end
        return res;
    endfunction

    function automatic logic [9:0] p10(input logic [9:0] k);
        return permute(k, 10, P10_IDX, 10);
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] k);
        return 8'(permute(k, 10, P8_IDX, 8));
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] s);
        return 4'(permute({6'b0, s}, 4, P4_IDX, 4));
    endfunction

    function automatic logic [7:0] ip(input logic [7:0] d);
        return 8'(permute({2'b0, d}, 8, IP_IDX, 8));
    endfunction

    function automatic logic [7:0] ipInv(input logic [7:0] d);
        return 8'(permute({2'b0, d}, 8, IP_INV_IDX, 8));
    endfunction

    function automatic logic [7:0] ep(input logic [3:0] r);
        return 8'(permute({6'b0, r}, 4, EP_IDX, 8));
    endfunction

    function automatic logic [9:0] ls1(input logic [9:0] k);
        return {k[8:5], k[9], k[3:0], k[4]};
    endfunction

    function automatic logic [9:0] ls2(input logic [9:0] k);
        return {k[7:5], k[9:8], k[2:0], k[4:3]};
    endfunction

    function automatic logic [7:0] sw(input logic [7:0] d);
        return {d[3:0], d[7:4]};
    endfunction

    function automatic logic [7:0] fk(input logic [7:0] d, input logic [7:0] k);
        logic [7:0] e;
        logic [3:0] s;
        e = ep(d[3:0]) ^ k;
        // Row comes from the outer bits of each nibble, column from the inner bits.
        s = {S0_TBL[{e[7], e[4], e[6], e[5]}], S1_TBL[{e[3], e[0], e[2], e[1]}]};
        return {d[7:4] ^ p4(s), d[3:0]};
    endfunction

endpackage

// File: rtl/sdes_decrypt_engine_if.sv
// Request/response bundle between the link receiver, the decryptor and the
// plaintext consumer.
interface sdes_decrypt_engine_if;
    logic       InValid;
    logic       InReady;
    logic [7:0] CipherText;
    logic [9:0] Key;
    logic       OutValid;
    logic       OutReady;
    logic [7:0] PlainText;
    logic       Busy;

    modport master (
        output InValid, CipherText, Key, OutReady,
        input  InReady, OutValid, PlainText, Busy
    );

    modport slave (
        input  InValid, CipherText, Key, OutReady,
        output InReady, OutValid, PlainText, Busy
    );
endinterface

// File: rtl/sdes_keygen.sv
// Combinational S-DES key schedule: 10-bit master key to subkeys K1 and K2.
module sdes_keygen
    import sdes_pkg::*;
(
    input  logic [9:0] key_i,
    output logic [7:0] k1_o,
    output logic [7:0] k2_o
);

    logic [9:0] shift1;

    assign shift1 = ls1(p10(key_i));
    assign k1_o   = p8(shift1);
    assign k2_o   = p8(ls2(shift1));

endmodule

// File: rtl/sdes_decrypt_engine.sv
// Multi-cycle S-DES decryptor: one request at a time, optional expanded-key
// cache, one shared fK round datapath.
module sdes_decrypt_engine
    import sdes_pkg::*;
#(
    parameter bit KEY_REUSE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    sdes_decrypt_engine_if.slave bus
);

    state_e     state_q, state_d;
    logic [7:0] ct_q, ct_d;
    logic [9:0] key_q, key_d;
    logic [7:0] k1_q, k1_d;
    logic [7:0] k2_q, k2_d;
    logic       cacheValid_q, cacheValid_d;
    logic [7:0] data_q, data_d;
    logic [7:0] plain_q, plain_d;
    logic       outValid_q, outValid_d;

    logic [7:0] genK1, genK2;
    logic [7:0] fkIn, fkKey, fkOut;
    logic       cacheHit;

    sdes_keygen u_keygen (
        .key_i (key_q),
        .k1_o  (genK1),
        .k2_o  (genK2)
    );

    // key_q doubles as the cached key: a hit only happens when the new key equals it.
    assign cacheHit = KEY_REUSE && cacheValid_q && (bus.Key == key_q);

    always_comb begin
        state_d      = state_q;
        ct_d         = ct_q;
        key_d        = key_q;
        k1_d         = k1_q;
        k2_d         = k2_q;
        cacheValid_d = cacheValid_q;
        data_d       = data_q;
        plain_d      = plain_q;
        outValid_d   = outValid_q;

        fkIn  = (state_q == RND_A) ? ip(ct_q) : sw(data_q);
        fkKey = (state_q == RND_A) ? k2_q : k1_q;
        fkOut = fk(fkIn, fkKey);

        case (state_q)
            IDLE: begin
                if (bus.InValid) begin
                    ct_d    = bus.CipherText;
                    key_d   = bus.Key;
                    state_d = cacheHit ? RND_A : KEYGEN;
                end
            end
            KEYGEN: begin
                k1_d         = genK1;
                k2_d         = genK2;
                cacheValid_d = 1'b1;
                state_d      = RND_A;
            end
            RND_A: begin
                data_d  = fkOut;
                state_d = RND_B;
            end
            RND_B: begin
                data_d     = fkOut;
                plain_d    = ipInv(fkOut);
                outValid_d = 1'b1;
                state_d    = OUT;
            end
            OUT: begin
                if (bus.OutReady) begin
                    outValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cacheValid_q <= 1'b0;
            plain_q      <= 8'h00;
            outValid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cacheValid_q <= cacheValid_d;
            plain_q      <= plain_d;
            outValid_q   <= outValid_d;
        end
    end

    // Pure datapath registers; their contents are qualified by state and cache valid.
    always_ff @(posedge clk) begin
        ct_q   <= ct_d;
        key_q  <= key_d;
        k1_q   <= k1_d;
        k2_q   <= k2_d;
        data_q <= data_d;
    end

    assign bus.InReady   = (state_q == IDLE);
    assign bus.Busy      = (state_q != IDLE);
    assign bus.OutValid  = outValid_q;
    assign bus.PlainText = plain_q;

endmodule

// File: tb/tb_sdes_decrypt_engine.sv
// Directed and round-trip bench for sdes_decrypt_engine, with a second
// instance built without key reuse for the latency comparison.
module tb_sdes_decrypt_engine;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sdes_decrypt_engine_if bus();
    sdes_decrypt_engine_if busNr();

    sdes_decrypt_engine #(.KEY_REUSE(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sdes_decrypt_engine #(.KEY_REUSE(1'b0)) dutNoReuse (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busNr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int sbox0 [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
    int sbox1 [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

    // Independent reference encryptor written with explicit bit picks.
    function automatic logic [7:0] refFk(input logic [7:0] d, input logic [7:0] k);
        logic [3:0] r;
        logic [7:0] e;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] s;
        r = d[3:0];
        e = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ k;
        a = 2'(sbox0[{e[7], e[4]}][{e[6], e[5]}]);
        b = 2'(sbox1[{e[3], e[0]}][{e[2], e[1]}]);
        s = {a, b};
        return {d[7:4] ^ {s[2], s[0], s[1], s[3]}, r};
    endfunction

    function automatic logic [7:0] refEncrypt(input logic [7:0] p, input logic [9:0] key);
        logic [9:0] t;
        logic [9:0] h1;
        logic [9:0] h2;
        logic [7:0] k1;
        logic [7:0] k2;
        logic [7:0] d;
        t  = {key[7], key[5], key[8], key[3], key[6], key[0], key[9], key[1], key[2], key[4]};
        h1 = {t[8:5], t[9], t[3:0], t[4]};
        h2 = {h1[7:5], h1[9:8], h1[2:0], h1[4:3]};
        k1 = {h1[4], h1[7], h1[3], h1[6], h1[2], h1[5], h1[0], h1[1]};
        k2 = {h2[4], h2[7], h2[3], h2[6], h2[2], h2[5], h2[0], h2[1]};
        d  = {p[6], p[2], p[5], p[7], p[4], p[0], p[3], p[1]};
        d  = refFk(d, k1);
        d  = {d[3:0], d[7:4]};
        d  = refFk(d, k2);
        return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one request and returns at the negedge where OutValid is first seen;
    // lat counts clock edges from the accept edge through the edge raising OutValid.
    task automatic applyStimulus(input logic [9:0] key, input logic [7:0] ct,
                                 output int lat, output logic [7:0] pt);
        int guard;
        @(negedge clk);
        bus.InValid    = 1'b1;
        bus.Key        = key;
        bus.CipherText = ct;
        guard = 0;
        while (!bus.InReady && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.InReady) checkOutput("inReady", 32'(bus.InReady), 32'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.InValid = 1'b0;
        while (!bus.OutValid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bus.OutValid) checkOutput("outValid", 32'(bus.OutValid), 32'd1);
        pt = bus.PlainText;
    endtask

    task automatic applyStimulusNr(input logic [9:0] key, input logic [7:0] ct,
                                   output int lat, output logic [7:0] pt);
        int guard;
        @(negedge clk);
        busNr.InValid    = 1'b1;
        busNr.Key        = key;
        busNr.CipherText = ct;
        guard = 0;
        while (!busNr.InReady && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!busNr.InReady) checkOutput("nrInReady", 32'(busNr.InReady), 32'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        busNr.InValid = 1'b0;
        while (!busNr.OutValid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!busNr.OutValid) checkOutput("nrOutValid", 32'(busNr.OutValid), 32'd1);
        pt = busNr.PlainText;
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         lat;
        int         expLat;
        logic [7:0] pt;
        logic [9:0] key;
        logic [9:0] lastKey;
        logic [7:0] p;
        logic [7:0] ct;

        total = 0;
        bad   = 0;
        key   = 10'b1010000010;

        rst_n            = 1'b0;
        bus.InValid      = 1'b0;
        bus.CipherText   = 8'h00;
        bus.Key          = 10'h000;
        bus.OutReady     = 1'b1;
        busNr.InValid    = 1'b0;
        busNr.CipherText = 8'h00;
        busNr.Key        = 10'h000;
        busNr.OutReady   = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstOutValid", 32'(bus.OutValid), 32'd0);
        checkOutput("rstPlainText", 32'(bus.PlainText), 32'h00);
        checkOutput("rstBusy", 32'(bus.Busy), 32'd0);
        checkOutput("rstInReady", 32'(bus.InReady), 32'd1);
        rst_n = 1'b1;

        // Textbook vector: K1=A4, K2=43, 0x77 decrypts to 0x72.
        applyStimulus(key, 8'h77, lat, pt);
        checkOutput("knownLatency", 32'(lat), 32'd4);
        checkOutput("knownPlain", 32'(pt), 32'h72);
        checkOutput("knownK1", 32'(dut.k1_q), 32'hA4);
        checkOutput("knownK2", 32'(dut.k2_q), 32'h43);
        @(negedge clk);
        checkOutput("doneOutValid", 32'(bus.OutValid), 32'd0);
        checkOutput("donePlainHeld", 32'(bus.PlainText), 32'h72);
        @(negedge clk);
        checkOutput("doneInReady", 32'(bus.InReady), 32'd1);

        applyStimulus(key, 8'h38, lat, pt);
        checkOutput("hitLatency", 32'(lat), 32'd3);
        checkOutput("hitPlain", 32'(pt), 32'h97);

        @(negedge clk);
        bus.OutReady = 1'b0;
        applyStimulus(key, 8'h77, lat, pt);
        checkOutput("bpLatency", 32'(lat), 32'd3);
        for (int i = 0; i < 10; i++) begin
            bus.InValid    = i[0];
            bus.CipherText = 8'(i * 37);
            @(negedge clk);
            checkOutput("bpHold", 32'({bus.OutValid, bus.InReady, bus.PlainText}), 32'h272);
        end
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        @(negedge clk);
        checkOutput("bpRelease", 32'(bus.OutValid), 32'd0);
        @(negedge clk);
        checkOutput("bpIdle", 32'({bus.InReady, bus.Busy}), 32'b10);

        // Cache hit lands straight in RND_A, where reset is applied.
        bus.InValid    = 1'b1;
        bus.Key        = key;
        bus.CipherText = 8'h38;
        @(posedge clk);
        @(negedge clk);
        bus.InValid = 1'b0;
        checkOutput("midBusy", 32'(bus.Busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midReset", 32'({bus.OutValid, bus.Busy, bus.InReady, bus.PlainText}), 32'h100);
        rst_n = 1'b1;
        applyStimulus(key, 8'h38, lat, pt);
        checkOutput("postRstLatency", 32'(lat), 32'd4);
        checkOutput("postRstPlain", 32'(pt), 32'h97);

        applyStimulusNr(key, 8'h77, lat, pt);
        checkOutput("nrFirstLatency", 32'(lat), 32'd4);
        checkOutput("nrFirstPlain", 32'(pt), 32'h72);
        applyStimulusNr(key, 8'h38, lat, pt);
        checkOutput("nrRepeatLatency", 32'(lat), 32'd4);
        checkOutput("nrRepeatPlain", 32'(pt), 32'h97);

        lastKey = key;
        for (int i = 0; i < 1024; i++) begin
            key    = 10'($urandom_range(0, 1023));
            p      = 8'($urandom_range(0, 255));
            ct     = refEncrypt(p, key);
            expLat = (key == lastKey) ? 3 : 4;
            lastKey = key;
            applyStimulus(key, ct, lat, pt);
            checkOutput("roundTripPlain", 32'(pt), 32'(p));
            checkOutput("roundTripLatency", 32'(lat), 32'(expLat));
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
